// File: rtl/timing_gen_pkg.sv
// timing_gen_pkg
// Shared types and helpers for the voice/envelope slot generator.
//   tg_state_e     : sequencer state (IDLE, ARMED, SCAN)
//   slots()        : slots per frame for a voice/envelope geometry
//   *_DEF          : default index widths for the 8x8 engine
package timing_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SCAN  = 2'd2
  } tg_state_e;

  localparam int unsigned V_WIDTH_DEF   = 3;
  localparam int unsigned E_WIDTH_DEF   = 3;
  localparam int unsigned IDX_WIDTH_DEF = V_WIDTH_DEF + E_WIDTH_DEF;

  function automatic int unsigned slots(input int unsigned voices,
                                        input int unsigned v_envs);
    return voices * v_envs;
  endfunction

endpackage

// File: rtl/timing_gen_mx_idx_delay_line.sv
// idx_delay_line
// DLY_TAPS-deep shift register on the slot index. Tap k (LSB-first in
// taps_o) is d_i delayed by k+1 clocks. Shifts every cycle, unconditionally.
//   sCLK_XVXENVS : clock (posedge)
//   iRST_N       : asynchronous active-low reset, all taps to 0
//   d_i          : index to delay
//   taps_o       : concatenated taps, tap 0 in the low W bits
module idx_delay_line
  import timing_gen_pkg::*;
#(
  parameter int unsigned W        = IDX_WIDTH_DEF,
  parameter int unsigned DLY_TAPS = 4
) (
  input  logic                  sCLK_XVXENVS,
  input  logic                  iRST_N,
  input  logic [W-1:0]          d_i,
  output logic [DLY_TAPS*W-1:0] taps_o
);

  logic [DLY_TAPS-1:0][W-1:0] taps_q;

  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) begin
      taps_q <= '0;
    end else begin
      taps_q[0] <= d_i;
      for (int k = 1; k < DLY_TAPS; k++) begin
        taps_q[k] <= taps_q[k-1];
      end
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/timing_gen_mx.sv
// timing_gen_mx
// Voice/envelope time-slot generator at the head of the synth engine.
// Produces a linear slot index with split voice/envelope fields, running
// free or one frame per sync pulse, plus delayed index taps and a sticky
// sync-overrun flag.
//
// state | meaning
// IDLE  | iRUN low or just raised; counters held at 0
// ARMED | sync mode, waiting for iSYNC; counters held at 0
// SCAN  | stepping through slots 0..N-1
//
// Ports:
//   sCLK_XVXENVS  slot clock (posedge; oWRAP_N on negedge)
//   iRST_N        asynchronous active-low reset
//   iRUN          enable, low forces IDLE
//   iFREE         1 = free-running, 0 = one frame per iSYNC
//   iSYNC         single-cycle frame-start request
//   iCLR_OVR      clears oOVERRUN (a simultaneous set wins)
//   oIDX/oVOICE/oENV  registered slot, voice and envelope indices
//   oIDX_D        delayed oIDX taps, tap k = k+1 cycles late
//   oFRAME_START/oFRAME_END  first/last slot strobes while scanning
//   oWRAP_N       last-slot flag re-registered on negedge
//   oBUSY         state is SCAN
//   oOVERRUN      sticky: iSYNC arrived mid-frame
module timing_gen_mx
  import timing_gen_pkg::*;
#(
  parameter int unsigned VOICES   = 8,
  parameter int unsigned V_ENVS   = 8,
  parameter int unsigned V_WIDTH  = V_WIDTH_DEF,
  parameter int unsigned E_WIDTH  = E_WIDTH_DEF,
  parameter int unsigned DLY_TAPS = 4
) (
  input  logic                                  sCLK_XVXENVS,
  input  logic                                  iRST_N,
  input  logic                                  iRUN,
  input  logic                                  iFREE,
  input  logic                                  iSYNC,
  input  logic                                  iCLR_OVR,
  output logic [V_WIDTH+E_WIDTH-1:0]            oIDX,
  output logic [V_WIDTH-1:0]                    oVOICE,
  output logic [E_WIDTH-1:0]                    oENV,
  output logic [DLY_TAPS*(V_WIDTH+E_WIDTH)-1:0] oIDX_D,
  output logic                                  oFRAME_START,
  output logic                                  oFRAME_END,
  output logic                                  oWRAP_N,
  output logic                                  oBUSY,
  output logic                                  oOVERRUN
);

  localparam int unsigned IW = V_WIDTH + E_WIDTH;
  localparam int unsigned N  = slots(VOICES, V_ENVS);

  if (N > 2**IW) begin : g_chk_n
    $error("timing_gen_mx: VOICES*V_ENVS does not fit the index width");
  end
  if (VOICES > 2**V_WIDTH) begin : g_chk_v
    $error("timing_gen_mx: VOICES does not fit V_WIDTH");
  end
  if (V_ENVS > 2**E_WIDTH) begin : g_chk_e
    $error("timing_gen_mx: V_ENVS does not fit E_WIDTH");
  end
  if (DLY_TAPS < 1) begin : g_chk_taps
    $error("timing_gen_mx: DLY_TAPS must be at least 1");
  end

  tg_state_e          state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [V_WIDTH-1:0] voice_q, voice_d;
  logic [E_WIDTH-1:0] env_q, env_d;
  logic               ovr_q, ovr_d;
  logic               wrap_q;
  logic               last_slot;
  logic               ovr_set;

  assign last_slot = (idx_q == IW'(N - 1));
  assign ovr_set   = (state_q == SCAN) && iSYNC && !last_slot;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    voice_d = voice_q;
    env_d   = env_q;
    ovr_d   = ovr_set ? 1'b1 : (iCLR_OVR ? 1'b0 : ovr_q);

    if (!iRUN) begin
      state_d = IDLE;
      idx_d   = '0;
      voice_d = '0;
      env_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = iFREE ? SCAN : ARMED;
          idx_d   = '0;
          voice_d = '0;
          env_d   = '0;
        end
        ARMED: begin
          // A switch to free mode while armed starts scanning without a sync.
          if (iSYNC || iFREE) state_d = SCAN;
          idx_d   = '0;
          voice_d = '0;
          env_d   = '0;
        end
        SCAN: begin
          if (last_slot) begin
            idx_d   = '0;
            voice_d = '0;
            env_d   = '0;
            // A sync landing on the last slot chains the next frame directly.
            if (!iFREE && !iSYNC) state_d = ARMED;
          end else begin
            idx_d = idx_q + IW'(1);
            if (env_q == E_WIDTH'(V_ENVS - 1)) begin
              env_d   = '0;
              voice_d = voice_q + V_WIDTH'(1);
            end else begin
              env_d = env_q + E_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          voice_d = '0;
          env_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      voice_q <= '0;
      env_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      voice_q <= voice_d;
      env_q   <= env_d;
      ovr_q   <= ovr_d;
    end
  end

  // Half-cycle-late copy of the last-slot flag: lets negedge-clocked
  // consumers see the wrap centred in the following slot.
  always_ff @(negedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) wrap_q <= 1'b0;
    else         wrap_q <= (state_q == SCAN) && last_slot;
  end

  idx_delay_line #(
    .W        (IW),
    .DLY_TAPS (DLY_TAPS)
  ) u_idx_delay_line (
    .sCLK_XVXENVS (sCLK_XVXENVS),
    .iRST_N       (iRST_N),
    .d_i          (idx_q),
    .taps_o       (oIDX_D)
  );

  assign oIDX         = idx_q;
  assign oVOICE       = voice_q;
  assign oENV         = env_q;
  assign oBUSY        = (state_q == SCAN);
  assign oFRAME_START = (state_q == SCAN) && (idx_q == '0);
  assign oFRAME_END   = (state_q == SCAN) && last_slot;
  assign oWRAP_N      = wrap_q;
  assign oOVERRUN     = ovr_q;

endmodule

// File: tb/tb_timing_gen_mx.sv
module tb_timing_gen_mx;

  logic clk = 1'b0, rst_n = 1'b0;
  logic run = 1'b0, free = 1'b0, sync = 1'b0, clr = 1'b0;

  // instance A: 8 voices x 8 envs ; instance B: 5 voices x 3 envs
  logic [5:0]  a_idx;  logic [2:0] a_voice; logic [2:0] a_env; logic [23:0] a_idxd;
  logic        a_fs, a_fe, a_wrap, a_busy, a_ovr;
  logic [4:0]  b_idx;  logic [2:0] b_voice; logic [1:0] b_env; logic [19:0] b_idxd;
  logic        b_fs, b_fe, b_wrap, b_busy, b_ovr;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  timing_gen_mx dut_a (
    .sCLK_XVXENVS(clk), .iRST_N(rst_n), .iRUN(run), .iFREE(free), .iSYNC(sync),
    .iCLR_OVR(clr), .oIDX(a_idx), .oVOICE(a_voice), .oENV(a_env), .oIDX_D(a_idxd),
    .oFRAME_START(a_fs), .oFRAME_END(a_fe), .oWRAP_N(a_wrap), .oBUSY(a_busy),
    .oOVERRUN(a_ovr));

  timing_gen_mx #(.VOICES(5), .V_ENVS(3), .V_WIDTH(3), .E_WIDTH(2), .DLY_TAPS(4)) dut_b (
    .sCLK_XVXENVS(clk), .iRST_N(rst_n), .iRUN(run), .iFREE(free), .iSYNC(sync),
    .iCLR_OVR(clr), .oIDX(b_idx), .oVOICE(b_voice), .oENV(b_env), .oIDX_D(b_idxd),
    .oFRAME_START(b_fs), .oFRAME_END(b_fe), .oWRAP_N(b_wrap), .oBUSY(b_busy),
    .oOVERRUN(b_ovr));

  // ---------------- reference model (slot-count level) ----------------
  int m_idx [2];
  bit m_busy [2], m_armed [2], m_ovr [2], m_wrap [2];
  int m_hist [2][4];

  function automatic int n_of(input int i);  return (i == 0) ? 64 : 15; endfunction
  function automatic int ve_of(input int i); return (i == 0) ? 8 : 3;   endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_idx[i] = 0; m_busy[i] = 0; m_armed[i] = 0; m_ovr[i] = 0; m_wrap[i] = 0;
      for (int k = 0; k < 4; k++) m_hist[i][k] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int n, old;
      bit ob;
      n = n_of(i); old = m_idx[i]; ob = m_busy[i];
      m_wrap[i] = ob && (old == n - 1);
      if (ob && sync && old != n - 1) m_ovr[i] = 1;
      else if (clr)                   m_ovr[i] = 0;
      for (int k = 3; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = old;
      if (!run) begin
        m_busy[i] = 0; m_armed[i] = 0; m_idx[i] = 0;
      end else if (ob) begin
        if (old == n - 1) begin
          m_idx[i] = 0;
          if (!free && !sync) begin m_busy[i] = 0; m_armed[i] = 1; end
        end else m_idx[i] = old + 1;
      end else if (m_armed[i]) begin
        if (sync || free) begin m_armed[i] = 0; m_busy[i] = 1; end
      end else begin
        if (free) m_busy[i] = 1; else m_armed[i] = 1;
      end
    end
  endtask

  function automatic logic [23:0] exp_taps_a();
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*6 +: 6] = m_hist[0][k][5:0];
    return r;
  endfunction

  function automatic logic [19:0] exp_taps_b();
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*5 +: 5] = m_hist[1][k][4:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; run = 0; free = 0; sync = 0; clr = 0;
    model_reset();
    #12;
    n_tests++; if (a_idx !== 6'd0)   begin n_fail++; $display("FAIL reset_idx: got %0d exp 0", a_idx); end
    n_tests++; if (a_idxd !== 24'd0) begin n_fail++; $display("FAIL reset_taps: got %h exp 0", a_idxd); end
    n_tests++; if (a_ovr !== 1'b0 || a_wrap !== 1'b0 || a_busy !== 1'b0)
      begin n_fail++; $display("FAIL reset_flags: ovr %b wrap %b busy %b exp 000", a_ovr, a_wrap, a_busy); end
    n_tests++; if (b_idx !== 5'd0 || b_voice !== 3'd0 || b_env !== 2'd0)
      begin n_fail++; $display("FAIL reset_b: idx %0d voice %0d env %0d exp 0", b_idx, b_voice, b_env); end
    @(posedge clk); #2; rst_n = 1;
    tick();
    n_tests++; if (a_busy !== 1'b0 || a_idx !== 6'd0)
      begin n_fail++; $display("FAIL idle_norun: busy %b idx %0d exp 0 0", a_busy, a_idx); end
  endtask

  task automatic test_free_mode();
    int fe_a = 0, fe_b = 0, wr_a = 0;
    free = 1; run = 1;
    for (int c = 1; c <= 140; c++) begin
      tick();
      if (c == 1) begin
        n_tests++; if (a_busy !== 1'b1 || a_idx !== 6'd0)
          begin n_fail++; $display("FAIL free_first: busy %b idx %0d exp 1 0", a_busy, a_idx); end
      end
      if (c == 2) begin
        n_tests++; if (a_idx !== 6'd1) begin n_fail++; $display("FAIL free_second: idx %0d exp 1", a_idx); end
      end
      n_tests++; if (a_idx !== 6'(m_idx[0]) || a_voice !== 3'(m_idx[0] / 8) || a_env !== 3'(m_idx[0] % 8))
        begin n_fail++; $display("FAIL free_a: idx %0d v %0d e %0d exp idx %0d", a_idx, a_voice, a_env, m_idx[0]); end
      n_tests++; if (b_idx !== 5'(m_idx[1]) || b_voice !== 3'(m_idx[1] / 3) || b_env !== 2'(m_idx[1] % 3))
        begin n_fail++; $display("FAIL free_b: idx %0d v %0d e %0d exp idx %0d", b_idx, b_voice, b_env, m_idx[1]); end
      n_tests++; if (a_wrap !== m_wrap[0])
        begin n_fail++; $display("FAIL free_wrap: got %b exp %b", a_wrap, m_wrap[0]); end
      if (a_fe === 1'b1) begin
        fe_a++;
        n_tests++; if (a_idx !== 6'd63 || a_voice !== 3'd7 || a_env !== 3'd7)
          begin n_fail++; $display("FAIL free_end_fields: idx %0d v %0d e %0d exp 63 7 7", a_idx, a_voice, a_env); end
      end
      if (b_fe === 1'b1) fe_b++;
      if (a_wrap === 1'b1) wr_a++;
    end
    n_tests++; if (fe_a != 2) begin n_fail++; $display("FAIL free_fe_count_a: got %0d exp 2", fe_a); end
    n_tests++; if (fe_b != 9) begin n_fail++; $display("FAIL free_fe_count_b: got %0d exp 9", fe_b); end
    n_tests++; if (wr_a != 2) begin n_fail++; $display("FAIL free_wrap_count: got %0d exp 2", wr_a); end
  endtask

  task automatic test_sync_mode();
    run = 0; tick();
    free = 0; run = 1; tick();
    n_tests++; if (a_busy !== 1'b0 || a_idx !== 6'd0)
      begin n_fail++; $display("FAIL sync_armed: busy %b idx %0d exp 0 0", a_busy, a_idx); end
    for (int f = 0; f < 3; f++) begin
      int ca = 0, cb = 0;
      sync = 1; tick(); sync = 0;
      for (int c = 0; c < 100; c++) begin
        if (c > 0) tick();
        if (a_busy === 1'b1) ca++;
        if (b_busy === 1'b1) cb++;
        n_tests++; if (a_idx !== 6'(m_idx[0]) || a_busy !== m_busy[0])
          begin n_fail++; $display("FAIL sync_step: idx %0d busy %b exp %0d %b", a_idx, a_busy, m_idx[0], m_busy[0]); end
      end
      n_tests++; if (ca != 64) begin n_fail++; $display("FAIL sync_busy_a: got %0d exp 64", ca); end
      n_tests++; if (cb != 15) begin n_fail++; $display("FAIL sync_busy_b: got %0d exp 15", cb); end
      n_tests++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL sync_no_ovr: got %b exp 0", a_ovr); end
    end
  endtask

  task automatic test_back_to_back();
    int g;
    sync = 1; tick(); sync = 0;
    for (g = 0; g < 200 && a_idx !== 6'd63; g++) tick();
    n_tests++; if (a_idx !== 6'd63) begin n_fail++; $display("FAIL b2b_wait63: timeout idx %0d exp 63", a_idx); end
    sync = 1; tick(); sync = 0;
    n_tests++; if (a_idx !== 6'd0 || a_busy !== 1'b1 || a_ovr !== 1'b0)
      begin n_fail++; $display("FAIL b2b_chain: idx %0d busy %b ovr %b exp 0 1 0", a_idx, a_busy, a_ovr); end
    for (g = 0; g < 200 && a_idx !== 6'd30; g++) tick();
    sync = 1; tick(); sync = 0;
    n_tests++; if (a_ovr !== 1'b1 || a_idx !== 6'd31)
      begin n_fail++; $display("FAIL ovr_set: ovr %b idx %0d exp 1 31", a_ovr, a_idx); end
    for (int c = 0; c < 32; c++) tick();
    n_tests++; if (a_idx !== 6'd63 || a_busy !== 1'b1)
      begin n_fail++; $display("FAIL ovr_len: idx %0d busy %b exp 63 1", a_idx, a_busy); end
    tick();
    n_tests++; if (a_busy !== 1'b0 || a_idx !== 6'd0)
      begin n_fail++; $display("FAIL ovr_end_armed: busy %b idx %0d exp 0 0", a_busy, a_idx); end
    clr = 1; tick(); clr = 0;
    n_tests++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b exp 0", a_ovr); end
    sync = 1; tick();
    n_tests++; if (a_busy !== 1'b1 || a_ovr !== 1'b0)
      begin n_fail++; $display("FAIL armed_sync_no_ovr: busy %b ovr %b exp 1 0", a_busy, a_ovr); end
    clr = 1; tick();
    n_tests++; if (a_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b exp 1", a_ovr); end
    sync = 0; tick(); clr = 0;
    n_tests++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clr2: got %b exp 0", a_ovr); end
  endtask

  task automatic test_abort();
    int g;
    free = 1;
    for (g = 0; g < 200 && a_idx !== 6'd20; g++) tick();
    n_tests++; if (a_idx !== 6'd20) begin n_fail++; $display("FAIL abort_wait20: timeout idx %0d", a_idx); end
    run = 0; tick();
    n_tests++; if (a_busy !== 1'b0 || a_idx !== 6'd0)
      begin n_fail++; $display("FAIL abort_idle: busy %b idx %0d exp 0 0", a_busy, a_idx); end
    n_tests++; if (a_idxd !== {6'd17, 6'd18, 6'd19, 6'd20})
      begin n_fail++; $display("FAIL abort_taps: got %h exp %h", a_idxd, {6'd17, 6'd18, 6'd19, 6'd20}); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++; if (a_idxd !== exp_taps_a())
        begin n_fail++; $display("FAIL abort_drain: got %h exp %h", a_idxd, exp_taps_a()); end
    end
    n_tests++; if (a_idxd !== 24'd0) begin n_fail++; $display("FAIL abort_drained: got %h exp 0", a_idxd); end
  endtask

  task automatic test_async_reset();
    int g;
    run = 1; free = 1; tick();
    for (g = 0; g < 200 && a_idx !== 6'd5; g++) tick();
    sync = 1; tick(); sync = 0;
    for (g = 0; g < 200 && a_idx !== 6'd63; g++) tick();
    #6;
    n_tests++; if (a_wrap !== 1'b1 || a_ovr !== 1'b1)
      begin n_fail++; $display("FAIL prereset_flags: wrap %b ovr %b exp 1 1", a_wrap, a_ovr); end
    rst_n = 0; model_reset();
    #1;
    n_tests++; if (a_idx !== 6'd0 || a_voice !== 3'd0 || a_env !== 3'd0 || a_idxd !== 24'd0)
      begin n_fail++; $display("FAIL areset_idx: idx %0d v %0d e %0d taps %h exp 0", a_idx, a_voice, a_env, a_idxd); end
    n_tests++; if (a_ovr !== 1'b0 || a_wrap !== 1'b0 || a_busy !== 1'b0 || a_fe !== 1'b0)
      begin n_fail++; $display("FAIL areset_flags: ovr %b wrap %b busy %b fe %b exp 0", a_ovr, a_wrap, a_busy, a_fe); end
    n_tests++; if (b_idx !== 5'd0 || b_idxd !== 20'd0)
      begin n_fail++; $display("FAIL areset_b: idx %0d taps %h exp 0", b_idx, b_idxd); end
    @(posedge clk); #2; rst_n = 1;
    tick();
    n_tests++; if (a_busy !== 1'b1 || a_idx !== 6'd0)
      begin n_fail++; $display("FAIL restart_first: busy %b idx %0d exp 1 0", a_busy, a_idx); end
    tick();
    n_tests++; if (a_idx !== 6'd1 || a_idxd !== exp_taps_a())
      begin n_fail++; $display("FAIL restart_second: idx %0d taps %h exp 1 %h", a_idx, a_idxd, exp_taps_a()); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      run  = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 63) == 0) free = ~free;
      sync = ($urandom_range(0, 19) == 0);
      clr  = ($urandom_range(0, 15) == 0);
      tick();
      n_tests++; if (a_idx !== 6'(m_idx[0]) || a_voice !== 3'(m_idx[0] / 8) || a_env !== 3'(m_idx[0] % 8))
        begin n_fail++; $display("FAIL rnd_a_idx: idx %0d v %0d e %0d exp idx %0d", a_idx, a_voice, a_env, m_idx[0]); end
      n_tests++; if (a_busy !== m_busy[0] || a_fs !== (m_busy[0] && m_idx[0] == 0) || a_fe !== (m_busy[0] && m_idx[0] == 63))
        begin n_fail++; $display("FAIL rnd_a_strobes: busy %b fs %b fe %b exp busy %b idx %0d", a_busy, a_fs, a_fe, m_busy[0], m_idx[0]); end
      n_tests++; if (a_wrap !== m_wrap[0] || a_ovr !== m_ovr[0])
        begin n_fail++; $display("FAIL rnd_a_flags: wrap %b ovr %b exp %b %b", a_wrap, a_ovr, m_wrap[0], m_ovr[0]); end
      n_tests++; if (a_idxd !== exp_taps_a())
        begin n_fail++; $display("FAIL rnd_a_taps: got %h exp %h", a_idxd, exp_taps_a()); end
      n_tests++; if (b_idx !== 5'(m_idx[1]) || b_voice !== 3'(m_idx[1] / 3) || b_env !== 2'(m_idx[1] % 3))
        begin n_fail++; $display("FAIL rnd_b_idx: idx %0d v %0d e %0d exp idx %0d", b_idx, b_voice, b_env, m_idx[1]); end
      n_tests++; if (b_busy !== m_busy[1] || b_fs !== (m_busy[1] && m_idx[1] == 0) || b_fe !== (m_busy[1] && m_idx[1] == 14))
        begin n_fail++; $display("FAIL rnd_b_strobes: busy %b fs %b fe %b exp busy %b idx %0d", b_busy, b_fs, b_fe, m_busy[1], m_idx[1]); end
      n_tests++; if (b_wrap !== m_wrap[1] || b_ovr !== m_ovr[1] || b_idxd !== exp_taps_b())
        begin n_fail++; $display("FAIL rnd_b_misc: wrap %b ovr %b taps %h exp %b %b %h", b_wrap, b_ovr, b_idxd, m_wrap[1], m_ovr[1], exp_taps_b()); end
    end
  endtask

  initial begin
    test_reset();
    test_free_mode();
    test_sync_mode();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timing_gen_mx.md
# timing_gen_mx

Parametrised voice/envelope time-slot generator for the synth engine, the successor to the fixed free-running slot counter. It produces a linear slot index plus split voice and envelope indices, and runs either continuously or one frame per sync pulse. It adds delayed index taps for downstream pipeline stages and flags sync overruns. It sits at the head of the synth_engine datapath and drives every time-multiplexed voice/envelope stage.

## Interface
Parameters:
- VOICES, 8, voices per frame
- V_ENVS, 8, envelopes per voice
- V_WIDTH, 3, voice index width
- E_WIDTH, 3, envelope index width
- DLY_TAPS, 4, number of delayed index taps (≥1)

Ports:
- sCLK_XVXENVS  in  1  slot clock; all state on posedge, except oWRAP_N, which updates on negedge
- iRST_N  in  1  asynchronous, active-low reset
- iRUN  in  1  enable; low forces IDLE
- iFREE  in  1  1 = free-running, 0 = one frame per iSYNC
- iSYNC  in  1  frame-start request, single-cycle, synchronous to sCLK_XVXENVS
- iCLR_OVR  in  1  clears oOVERRUN
- oIDX  out  V_WIDTH+E_WIDTH  linear slot index 0..N-1, where N = VOICES*V_ENVS
- oVOICE  out  V_WIDTH  current voice
- oENV  out  E_WIDTH  current envelope
- oIDX_D  out  DLY_TAPS*(V_WIDTH+E_WIDTH)  tap k (LSB-first) = oIDX delayed k+1 cycles
- oFRAME_START  out  1  SCAN and oIDX==0
- oFRAME_END  out  1  SCAN and oIDX==N-1
- oWRAP_N  out  1  negedge-registered copy of the last-slot flag
- oBUSY  out  1  state==SCAN
- oOVERRUN  out  1  sticky sync-overrun flag

## Operation
- States:
  - IDLE: counters held at 0.
  - ARMED: waiting for iSYNC, counters held at 0.
  - SCAN: counting.
- Transitions, evaluated at each posedge:
  - !iRUN: any state → IDLE, all counters 0. Aborts mid-frame.
  - IDLE with iRUN: iFREE ? SCAN : ARMED.
  - ARMED with iSYNC: → SCAN.
  - SCAN, oIDX<N-1: oIDX+1.
  - SCAN, oIDX==N-1, free mode: oIDX←0, stay in SCAN.
  - SCAN, oIDX==N-1, sync mode: oIDX←0. If iSYNC is high that cycle, stay in SCAN (back-to-back frames); otherwise → ARMED.
- Counter fields:
  - oENV counts 0..V_ENVS-1.
  - oVOICE increments when oENV wraps and returns to 0 after VOICES-1.
  - Invariant: oIDX == oVOICE*V_ENVS + oENV.
- iFREE changes take effect only at frame end or from IDLE/ARMED.
- Overrun:
  - iSYNC in SCAN with oIDX≠N-1 sets oOVERRUN and is otherwise ignored.
  - iSYNC in IDLE is ignored and does not set oOVERRUN.
  - iCLR_OVR clears oOVERRUN. If set and clear occur in the same cycle, set wins.
- Elaboration checks (error if violated):
  - N ≤ 2^(V_WIDTH+E_WIDTH)
  - VOICES ≤ 2^V_WIDTH
  - V_ENVS ≤ 2^E_WIDTH

## Timing
- Reset values: oIDX, oVOICE, oENV, every oIDX_D tap, oOVERRUN, oWRAP_N all 0; state IDLE.
- oIDX, oVOICE and oENV are registers. Strobes are decoded from registered state and index only, with no input-to-output combinational paths.
- iRUN rises at posedge t:
  - Free mode: state becomes SCAN at t+1 and oIDX=0 at t+1. First oIDX=1 at t+2.
  - Sync mode: state becomes ARMED at t+1.
- Sync mode, iSYNC sampled high at posedge t in ARMED: SCAN with oIDX=0..N-1 at t+1..t+N.
- oWRAP_N samples (SCAN && oIDX==N-1) on each negedge. It rises at the negedge inside the last slot and falls at the negedge inside the next slot.
- oIDX_D tap k lags oIDX by exactly k+1 posedges, including across wrap, abort and IDLE. Taps shift every cycle regardless of state.

## Structure
- Package timing_gen_pkg:
  - state enum {IDLE, ARMED, SCAN}
  - localparam function slots(VOICES, V_ENVS)
  - index width localparam
- Sub-module idx_delay_line: parametrised DLY_TAPS-deep shift register with async reset, instantiated once on oIDX.

## Test plan
- Free mode, defaults, iRUN=1 after reset → oIDX 0..63 repeating. oFRAME_END at oIDX=63, oVOICE=7, oENV=7. oWRAP_N toggles on negedge, once per 64 cycles.
- Sync mode, iSYNC every 100 cycles → 64 SCAN cycles, then ARMED with oIDX=0 for 36 cycles. oBUSY high for exactly 64 cycles.
- Sync mode, iSYNC at oIDX=63 → next frame starts immediately with oIDX=0 and no ARMED cycle. iSYNC at oIDX=30 → oOVERRUN=1, frame length unchanged. iCLR_OVR → 0.
- VOICES=5, V_ENVS=3, widths 3/2 → oIDX 0..14. oENV sequence 0,1,2 repeating; oVOICE 0..4. Invariant holds every cycle.
- iRUN dropped at oIDX=20 → IDLE next cycle, oIDX=0. oIDX_D taps show 20,19,… draining over 4 cycles.
- iRST_N asserted mid-frame, asynchronously between edges → all outputs 0 immediately. Restart behaves as after power-up.
